// File: rtl/cf_pkg.sv
// Shared constants for the fetch/decode stage: address width, PC step and
// the MSB position of every R-type instruction field.
package cf_pkg;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  localparam int OP_MSB    = 31;
  localparam int RS_MSB    = 25;
  localparam int RT_MSB    = 20;
  localparam int RD_MSB    = 15;
  localparam int SHAMT_MSB = 10;
  localparam int FUNCT_MSB = 5;
endpackage

// File: rtl/inst_mem.sv
// Read-only byte-wide instruction memory with a combinational big-endian
// 32-bit read; byte addresses wrap so a word may straddle the top of memory.
module inst_mem
  import cf_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word
);
  // NOTE: storage is preloaded externally and deliberately has no reset or
  // write path; clearing a memory on reset would wipe the program.
  logic [7:0] instBank [0:MEM_DEPTH-1];

  logic [ADDR_W-1:0] addr1, addr2, addr3;

  assign addr1 = addr + ADDR_W'(1);
  assign addr2 = addr + ADDR_W'(2);
  assign addr3 = addr + ADDR_W'(3);

  assign word = {instBank[addr], instBank[addr1], instBank[addr2], instBank[addr3]};
endmodule

// File: rtl/cf_fetch.sv
// Fetch and R-type field decode: free-running PC stepping by 4 bytes,
// combinational instruction read and field slicing in the same cycle.
module cf_fetch
  import cf_pkg::*;
(
  input  logic              clk_CF,
  input  logic              rstn_CF,
  input  logic [ADDR_W-1:0] initialPCCF,
  output logic [ADDR_W-1:0] MemAddrRegCF,
  output logic [5:0]        op_CF,
  output logic [4:0]        rsCF,
  output logic [4:0]        rtCF,
  output logic [4:0]        rdCF,
  output logic [4:0]        shamtCF,
  output logic [5:0]        functCF
);
  logic [ADDR_W-1:0] pc_q;
  logic              load_q;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;

  // Until the first edge after reset the PC follows initialPCCF directly, so
  // the register itself only needs a constant reset value.
  assign pc = load_q ? initialPCCF : pc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge.
  always_ff @(posedge clk_CF or negedge rstn_CF) begin
    if (!rstn_CF) begin
      load_q <= 1'b1;
      pc_q   <= '0;
    end else begin
      load_q <= 1'b0;
      pc_q   <= pc + PC_STEP;
    end
  end

  inst_mem IMCF (
    .addr (pc),
    .word (instr)
  );

  assign MemAddrRegCF = pc;
  assign op_CF        = instr[OP_MSB    -: 6];
  assign rsCF         = instr[RS_MSB    -: 5];
  assign rtCF         = instr[RT_MSB    -: 5];
  assign rdCF         = instr[RD_MSB    -: 5];
  assign shamtCF      = instr[SHAMT_MSB -: 5];
  assign functCF      = instr[FUNCT_MSB -: 6];
endmodule

// File: tb/tb_cf_fetch.sv
// Self-checking bench for cf_fetch against a byte-array memory model and an
// arithmetic PC model.
module tb_cf_fetch;
  logic       clk_CF;
  logic       rstn_CF;
  logic [7:0] initialPCCF;
  logic [7:0] MemAddrRegCF;
  logic [5:0] op_CF;
  logic [4:0] rsCF, rtCF, rdCF, shamtCF;
  logic [5:0] functCF;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_model [0:255];
  logic [7:0] pc_model;

  cf_fetch cftb (
    .clk_CF       (clk_CF),
    .rstn_CF      (rstn_CF),
    .initialPCCF  (initialPCCF),
    .MemAddrRegCF (MemAddrRegCF),
    .op_CF        (op_CF),
    .rsCF         (rsCF),
    .rtCF         (rtCF),
    .rdCF         (rdCF),
    .shamtCF      (shamtCF),
    .functCF      (functCF)
  );

  initial clk_CF = 1'b0;
  always #10 clk_CF = ~clk_CF;

  task automatic poke(input int a, input logic [7:0] v);
    cftb.IMCF.instBank[a] = v;
    mem_model[a] = v;
  endtask

  function automatic logic [31:0] model_instr(input logic [7:0] p);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = mem_model[8'((int'(p) + i) % 256)];
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] dut_fields();
    return {op_CF, rsCF, rtCF, rdCF, shamtCF, functCF};
  endfunction

  task automatic clock_step();
    @(posedge clk_CF);
    pc_model = 8'((int'(pc_model) + 4) % 256);
    #1;
  endtask

  task automatic enter_reset(input logic [7:0] init_pc);
    @(negedge clk_CF);
    initialPCCF = init_pc;
    rstn_CF = 1'b0;
    pc_model = init_pc;
    #1;
  endtask

  task automatic leave_reset();
    @(negedge clk_CF);
    rstn_CF = 1'b1;
    #1;
  endtask

  task automatic cmp_state(input string name);
    total++;
    if (MemAddrRegCF !== pc_model) begin
      bad++;
      $display("FAIL %s pc: got %h want %h", name, MemAddrRegCF, pc_model);
    end
    total++;
    if (dut_fields() !== model_instr(pc_model)) begin
      bad++;
      $display("FAIL %s instr @%h: got %h want %h", name, pc_model, dut_fields(),
               model_instr(pc_model));
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 256; a++) poke(a, 8'($urandom));
    poke(0, 8'h02); poke(1, 8'h32); poke(2, 8'h40); poke(3, 8'h20);
    enter_reset(8'h00);
    total++;
    if ({MemAddrRegCF, op_CF, rsCF, rtCF, rdCF, shamtCF, functCF} !==
        {8'h00, 6'd0, 5'd17, 5'd18, 5'd8, 5'd0, 6'h20}) begin
      bad++;
      $display("FAIL reset_add: got pc=%h op=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%h",
               MemAddrRegCF, op_CF, rsCF, rtCF, rdCF, shamtCF, functCF);
    end
    cmp_state("reset_model");
  endtask

  task automatic test_step();
    leave_reset();
    cmp_state("after_release");
    for (int i = 0; i < 3; i++) begin
      clock_step();
      cmp_state("step");
    end
    total++;
    if (MemAddrRegCF !== 8'h0C) begin
      bad++;
      $display("FAIL step_0c: got %h want 0c", MemAddrRegCF);
    end
  endtask

  task automatic test_wrap();
    poke(8'hFC, 8'h00); poke(8'hFD, 8'h08); poke(8'hFE, 8'h48); poke(8'hFF, 8'h80);
    enter_reset(8'hFC);
    leave_reset();
    total++;
    if ({rtCF, rdCF, shamtCF, functCF} !== {5'd8, 5'd9, 5'd2, 6'd0}) begin
      bad++;
      $display("FAIL wrap_sll: got rt=%0d rd=%0d sh=%0d fn=%0d", rtCF, rdCF, shamtCF, functCF);
    end
    clock_step();
    total++;
    if (MemAddrRegCF !== 8'h00) begin
      bad++;
      $display("FAIL wrap_pc: got %h want 00", MemAddrRegCF);
    end
    cmp_state("wrap_model");
  endtask

  task automatic test_straddle();
    poke(8'hFE, 8'hAB); poke(8'hFF, 8'hCD); poke(8'h00, 8'hEF); poke(8'h01, 8'h01);
    enter_reset(8'hFE);
    total++;
    if ({op_CF, rsCF, rtCF, rdCF, shamtCF, functCF} !==
        {6'h2A, 5'd30, 5'd13, 5'd29, 5'd28, 6'h01}) begin
      bad++;
      $display("FAIL straddle: got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h",
               op_CF, rsCF, rtCF, rdCF, shamtCF, functCF);
    end
    leave_reset();
    clock_step();
    total++;
    if (MemAddrRegCF !== 8'h02) begin
      bad++;
      $display("FAIL wrap_fe: got %h want 02", MemAddrRegCF);
    end
    cmp_state("straddle_next");
  endtask

  task automatic test_async_reset();
    enter_reset(8'h00);
    leave_reset();
    for (int i = 0; i < 4; i++) clock_step();
    cmp_state("run_to_10");
    @(negedge clk_CF);
    #3;
    initialPCCF = 8'h20;
    rstn_CF = 1'b0;
    pc_model = 8'h20;
    #1;
    total++;
    if (MemAddrRegCF !== 8'h20) begin
      bad++;
      $display("FAIL async_reset: got %h want 20", MemAddrRegCF);
    end
    cmp_state("async_model");
    leave_reset();
    clock_step();
    total++;
    if (MemAddrRegCF !== 8'h24) begin
      bad++;
      $display("FAIL restart_24: got %h want 24", MemAddrRegCF);
    end
  endtask

  task automatic test_program();
    int diffs;
    for (int a = 0; a < 80; a++) poke(a, 8'($urandom));
    enter_reset(8'h00);
    leave_reset();
    for (int w = 0; w < 20; w++) begin
      cmp_state("program");
      clock_step();
    end
    enter_reset(8'h00);
    leave_reset();
    diffs = 0;
    for (int a = 0; a < 256; a++)
      if (cftb.IMCF.instBank[a] !== mem_model[a]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL mem_kept: got %0d changed bytes want 0", diffs);
    end
  endtask

  task automatic test_random_pc();
    for (int t = 0; t < 8; t++) begin
      enter_reset(8'($urandom));
      cmp_state("rand_reset");
      leave_reset();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        clock_step();
        cmp_state("rand_step");
      end
    end
  endtask

  initial begin
    rstn_CF = 1'b0;
    initialPCCF = 8'h00;
    pc_model = 8'h00;
    test_reset();
    test_step();
    test_wrap();
    test_straddle();
    test_async_reset();
    test_program();
    test_random_pc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
